dm_store_rmw: RTL

Sub-word store unit between the CPU's memory stage and a word-only data memory. It accepts sw/sh/sb requests and writes full words directly. For sh/sb it performs a read-modify-write: read the word, merge the narrowed byte or halfword into the correct lane, write the word back. It is the store-side counterpart of the immediate/load extenders, narrowing and packing data where they widen it.

---
 rtl/dm_store_rmw_pkg.sv | 33 +++
 rtl/dm_store_rmw_merge.sv | 26 ++
 rtl/dm_store_rmw.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dm_store_rmw_pkg.sv
// Shared definitions for the sub-word store unit: op encodings, FSM states,
// lane widths and the alignment rule used by DM_RMW_ALIGN_CHECK_EN builds.
package dm_store_rmw_pkg;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // sw must be word aligned, sh halfword aligned; sb and reserved never fault.
    function automatic logic misaligned(input op_e op, input logic [1:0] lane);
        case (op)
            OP_SW:   return lane != 2'b00;
            OP_SH:   return lane[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_rmw_merge.sv
// Combinational lane merge: drops the narrowed store data into the addressed
// little-endian lane of the old word. sw replaces the whole word; reserved
// ops leave the old word untouched.
module dm_store_rmw_merge
    import dm_store_rmw_pkg::*;
(
    input  op_e               op,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] merged
);

    // Overlay the byte/halfword on the old word at its lane offset.
    always_comb begin
        // NOTE: default assignment first keeps this block purely combinational (no latch).
        merged = old_word;
        case (op)
            OP_SW:   merged = wdata;
            OP_SH:   merged[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            OP_SB:   merged[{lane, 3'b000} +: BYTE_W]     = wdata[BYTE_W-1:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dm_store_rmw.sv
// Sub-word store unit in front of a word-only data memory. sw writes directly;
// sh/sb read the word, merge the lane and write it back. Define
// DM_RMW_ALIGN_CHECK_EN to drop misaligned sw/sh with an err pulse; otherwise
// the low misaligned address bits are simply ignored.
module dm_store_rmw
    import dm_store_rmw_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              err
);

    state_e              state;
    op_e                 op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   merged;
    logic                ready_q;
    logic                re_q;
    logic                we_q;
    logic                done_q;
    op_e                 req_op_e;
    logic                unused_addr_hi;

    assign req_op_e       = op_e'(req_op);
    // Byte-address bits above the memory's range are deliberately discarded.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    dm_store_rmw_merge u_merge (
        .op       (op_q),
        .lane     (addr_q[1:0]),
        .old_word (word_q),
        .wdata    (wdata_q),
        .merged   (merged)
    );

`ifdef DM_RMW_ALIGN_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Store FSM: accept in IDLE, optional read/merge, single write, back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: latched request/word registers are reset too, so outputs derived from them start at 0.
            state   <= ST_IDLE;
            op_q    <= OP_SW;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            ready_q <= 1'b1;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef DM_RMW_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere so each register sees pre-edge values of the others.
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef DM_RMW_ALIGN_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
`ifdef DM_RMW_ALIGN_CHECK_EN
                        if (misaligned(req_op_e, req_addr[1:0])) begin
                            state <= ST_ERR;
                            err_q <= 1'b1;
                        end else
`endif
                        if (req_op_e == OP_SH || req_op_e == OP_SB) begin
                            state <= ST_RD;
                            re_q  <= 1'b1;
                        end else begin
                            // Reserved op walks through WR only to pulse done.
                            state  <= ST_WR;
                            we_q   <= (req_op_e != OP_RSV);
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_MRG;
                end
                ST_MRG: begin
                    word_q <= mem_rdata;
                    state  <= ST_WR;
                    we_q   <= 1'b1;
                    done_q <= 1'b1;
                end
                default: begin
                    // WR and ERR both last one cycle and return to IDLE.
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign done      = done_q;
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = (state == ST_WR && op_q != OP_RSV) ? merged : '0;

endmodule
